// File: rtl/mem_responder.sv
// Byte-wide memory responder for the multicycle MIPS core: services memread/memwrite
// after LATENCY wait states and pulses ready for one cycle; preloadable while in reset.
module mem_responder #(
  parameter int WIDTH   = 8,
  parameter int AWIDTH  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [AWIDTH-1:0] adr,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              load_en,
  input  logic [AWIDTH-1:0] load_adr,
  input  logic [WIDTH-1:0]  load_data,
  output logic [WIDTH-1:0]  readdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic [AWIDTH-1:0] adr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              wr_q;

  logic              req;
  logic              commit;
  logic              commit_wr;
  logic [AWIDTH-1:0] commit_adr;
  logic [WIDTH-1:0]  commit_data;

  logic [WIDTH-1:0]  mem [2**AWIDTH];

  assign req   = memread | memwrite;
  assign ready = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

  // With zero wait states the access commits straight from the live request
  // inputs on the capture edge; otherwise it commits from the captured copies.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_next  = state;
    commit      = 1'b0;
    commit_wr   = wr_q;
    commit_adr  = adr_q;
    commit_data = wdata_q;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_next  = ST_DONE;
            commit      = 1'b1;
            commit_wr   = memwrite;
            commit_adr  = adr;
            commit_data = writedata;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_DONE;
          commit     = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req) begin
        cnt <= CNT_INIT;
        if (memread && memwrite) err <= 1'b1;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !commit_wr) readdata <= mem[commit_adr];
    end
  end

  // Request capture needs no reset: it is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_IDLE && req) begin
      adr_q   <= adr;
      wdata_q <= writedata;
      wr_q    <= memwrite;
    end
  end

  // NOTE: the array is deliberately not reset; reset is the window in which
  // program images are preloaded, so clearing it would destroy them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_en) mem[load_adr] <= load_data;
    end else if (commit && commit_wr) begin
      mem[commit_adr] <= commit_data;
    end
  end

endmodule
